// File: rtl/point_doubling.sv
// point_doubling: affine elliptic-curve point doubling 2P over GF(p), single-shot after reset
// Ports: clk, reset (sync, active-high); p, x1, y1, a operands captured on the first
// edge after reset; x3, y3 result of 2P; result high while x3/y3 valid; infinity high
// when 2P is the point at infinity.
// Option: POINT_DOUBLING_REDUCE_IN_EN adds a REDUCE step accepting inputs below 2p.
module point_doubling #(
  parameter int n = 530
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [n-1:0] p,
  input  logic [n-1:0] x1,
  input  logic [n-1:0] y1,
  input  logic [n-1:0] a,
  output logic [n-1:0] x3,
  output logic [n-1:0] y3,
  output logic         result,
  output logic         infinity
);
  localparam int CW = $clog2(n);
  localparam logic [CW-1:0] CN = CW'(n - 1);
  typedef enum logic [3:0] {
    S_LOAD,
`ifdef POINT_DOUBLING_REDUCE_IN_EN
    S_REDUCE,
`endif
    S_INF, S_SQ, S_T2, S_T3, S_TA, S_INV, S_LM, S_L2, S_X1, S_X2, S_DX, S_YM, S_YS, S_DONE
  } state_t;
  state_t r_state, w_state_n;
  logic [n-1:0] r_p, r_x1, r_y1, r_a, r_t, r_num, r_l, r_xr, r_yr;
  logic [n-1:0] r_u, r_v, r_g1, r_g2, r_acc;
  logic [CW-1:0] r_cnt;
  logic [n-1:0] w_ma, w_mb, w_prod, w_inv;
  logic [n+1:0] w_pp, w_m0, w_m1, w_m2;
  logic w_mul, w_mdone, w_idone;

  function automatic logic [n-1:0] f_add(input logic [n-1:0] x, y, m);
    logic [n:0] s;
    s = {1'b0, x} + {1'b0, y};
    return n'(s >= {1'b0, m} ? s - {1'b0, m} : s);
  endfunction

  function automatic logic [n-1:0] f_sub(input logic [n-1:0] x, y, m);
    logic [n:0] s;
    s = {1'b0, x} - {1'b0, y};
    return n'(x >= y ? s : s + {1'b0, m});
  endfunction

  // halving mod p: make the value even by adding the odd modulus, then shift
  function automatic logic [n-1:0] f_half(input logic [n-1:0] x, m);
    logic [n:0] s;
    s = x[0] ? {1'b0, x} + {1'b0, m} : {1'b0, x};
    return n'(s >> 1);
  endfunction

`ifdef POINT_DOUBLING_REDUCE_IN_EN
  function automatic logic [n-1:0] f_red(input logic [n-1:0] x, m);
    return x >= m ? x - m : x;
  endfunction
`endif

  // one MSB-first interleaved step: acc = 2*acc + b[cnt]*a, kept below p
  always_comb begin
    w_mul = r_state inside {S_SQ, S_LM, S_L2, S_YM};
    w_mdone = r_cnt == '0;
    w_idone = r_u == n'(1) || r_v == n'(1);
    w_inv = r_u == n'(1) ? r_g1 : r_g2;
    w_ma = r_state == S_SQ ? r_x1 : r_state == S_LM ? r_num : r_l;
    w_mb = r_state == S_SQ ? r_x1 : r_state == S_LM ? w_inv : r_state == S_L2 ? r_l : r_t;
    w_pp = {2'b0, r_p};
    w_m0 = {1'b0, r_acc, 1'b0};
    w_m1 = w_m0 >= w_pp ? w_m0 - w_pp : w_m0;
    w_m2 = w_mb[r_cnt] ? w_m1 + {2'b0, w_ma} : w_m1;
    w_prod = n'(w_m2 >= w_pp ? w_m2 - w_pp : w_m2);
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
`ifdef POINT_DOUBLING_REDUCE_IN_EN
      S_LOAD:   w_state_n = S_REDUCE;
      S_REDUCE: w_state_n = f_red(r_y1, r_p) == '0 ? S_INF : S_SQ;
`else
      S_LOAD:   w_state_n = y1 == '0 ? S_INF : S_SQ;
`endif
      S_SQ:     w_state_n = w_mdone ? S_T2 : S_SQ;
      S_T2:     w_state_n = S_T3;
      S_T3:     w_state_n = S_TA;
      S_TA:     w_state_n = S_INV;
      S_INV:    w_state_n = w_idone ? S_LM : S_INV;
      S_LM:     w_state_n = w_mdone ? S_L2 : S_LM;
      S_L2:     w_state_n = w_mdone ? S_X1 : S_L2;
      S_X1:     w_state_n = S_X2;
      S_X2:     w_state_n = S_DX;
      S_DX:     w_state_n = S_YM;
      S_YM:     w_state_n = w_mdone ? S_YS : S_YM;
      S_YS:     w_state_n = S_DONE;
      default:  w_state_n = r_state;
    endcase
  end

  always_ff @(posedge clk)
    r_state <= reset ? S_LOAD : w_state_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      x3 <= '0;
      y3 <= '0;
      result <= 1'b0;
      infinity <= 1'b0;
    end else begin
      result <= w_state_n == S_DONE;
      infinity <= w_state_n == S_INF;
      if (w_mul) begin
        r_acc <= w_mdone ? '0 : w_prod;
        r_cnt <= w_mdone ? CN : r_cnt - 1'b1;
      end
      case (r_state)
        S_LOAD: begin
          r_p <= p;
          r_x1 <= x1;
          r_y1 <= y1;
          r_a <= a;
          r_acc <= '0;
          r_cnt <= CN;
        end
`ifdef POINT_DOUBLING_REDUCE_IN_EN
        S_REDUCE: begin
          r_x1 <= f_red(r_x1, r_p);
          r_y1 <= f_red(r_y1, r_p);
          r_a <= f_red(r_a, r_p);
        end
`endif
        S_SQ: if (w_mdone) r_t <= w_prod;
        S_T2: begin
          r_num <= f_add(r_t, r_t, r_p);
          r_u <= f_add(r_y1, r_y1, r_p);
          r_v <= r_p;
          r_g1 <= n'(1);
          r_g2 <= '0;
        end
        S_T3: r_num <= f_add(r_num, r_t, r_p);
        S_TA: r_num <= f_add(r_num, r_a, r_p);
        // invariants g1*den = u, g2*den = v (mod p); subtract-and-halve keeps it within 2n steps
        S_INV: if (!w_idone) begin
          if (!r_u[0]) begin
            r_u <= r_u >> 1;
            r_g1 <= f_half(r_g1, r_p);
          end else if (!r_v[0]) begin
            r_v <= r_v >> 1;
            r_g2 <= f_half(r_g2, r_p);
          end else if (r_u >= r_v) begin
            r_u <= (r_u - r_v) >> 1;
            r_g1 <= f_half(f_sub(r_g1, r_g2, r_p), r_p);
          end else begin
            r_v <= (r_v - r_u) >> 1;
            r_g2 <= f_half(f_sub(r_g2, r_g1, r_p), r_p);
          end
        end
        S_LM: if (w_mdone) r_l <= w_prod;
        S_L2: if (w_mdone) r_xr <= w_prod;
        S_X1, S_X2: r_xr <= f_sub(r_xr, r_x1, r_p);
        S_DX: r_t <= f_sub(r_x1, r_xr, r_p);
        S_YM: if (w_mdone) r_yr <= w_prod;
        S_YS: begin
          x3 <= r_xr;
          y3 <= f_sub(r_yr, r_y1, r_p);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_point_doubling.sv
// tb_point_doubling: vector, random and corner-sequence checks of point_doubling
module tb_point_doubling;
  localparam int W = 530;
  typedef logic [W-1:0] big_t;
  typedef logic [2*W-1:0] dbl_t;
  typedef struct {
    logic [15:0] p, a, x, y, ex, ey;
    bit inf;
  } vec_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rs, rb, res_s, inf_s, res_b, inf_b;
  logic [15:0] ps, as, xs, ys, x3s, y3s;
  big_t pb, ab, xb, yb, x3b, y3b;
  int total = 0, bad = 0;

  point_doubling #(.n(16)) u_s (
    .clk(clk), .reset(rs), .p(ps), .x1(xs), .y1(ys), .a(as),
    .x3(x3s), .y3(y3s), .result(res_s), .infinity(inf_s)
  );
  point_doubling #(.n(W)) u_b (
    .clk(clk), .reset(rb), .p(pb), .x1(xb), .y1(yb), .a(ab),
    .x3(x3b), .y3(y3b), .result(res_b), .infinity(inf_b)
  );

  function automatic dbl_t z(input big_t v);
    return {{W{1'b0}}, v};
  endfunction

  function automatic big_t md(input dbl_t w, input big_t m);
    dbl_t r;
    r = w % z(m);
    return r[W-1:0];
  endfunction

  function automatic big_t pw(input big_t b, input big_t e, input big_t m);
    big_t r;
    r = 1;
    for (int i = W - 1; i >= 0; i--) begin
      r = md(z(r) * z(r), m);
      if (e[i]) r = md(z(r) * z(b), m);
    end
    return r;
  endfunction

  // textbook doubling with Fermat inverse
  function automatic void ref_dbl(input big_t p, input big_t a, input big_t x, input big_t y,
                                  output big_t rx, output big_t ry, output bit inf);
    big_t t, num, den, l;
    inf = (y == '0);
    rx = '0;
    ry = '0;
    if (!inf) begin
      t = md(z(x) * z(x), p);
      num = md(z(t) + z(t) + z(t) + z(a), p);
      den = md(z(y) + z(y), p);
      l = md(z(num) * z(pw(den, p - big_t'(2), p)), p);
      rx = md(z(l) * z(l) + z(p) + z(p) - z(x) - z(x), p);
      ry = md(z(l) * (z(x) + z(p) - z(rx)) + z(p) - z(y), p);
    end
  endfunction

  task automatic chk(input string nm, input big_t got, input big_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic start_s(input logic [15:0] p, input logic [15:0] a, input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    rs = 1'b1;
    ps = p; as = a; xs = x; ys = y;
    @(negedge clk);
    rs = 1'b0;
    @(posedge clk);
    #1;
    ps = 16'($urandom); as = 16'($urandom); xs = 16'($urandom); ys = 16'($urandom);
  endtask

  task automatic wait_s(output int k, output bit part);
    k = 0;
    part = 1'b0;
    while (!res_s && !inf_s && k < 400) begin
      @(posedge clk);
      #1;
      k++;
      if (!res_s && (x3s != '0 || y3s != '0)) part = 1'b1;
    end
  endtask

  task automatic check_s(input string nm, input logic [15:0] ex, input logic [15:0] ey, input bit einf,
                         input int k, input bit part);
    chk({nm, ".inf"}, big_t'(inf_s), big_t'(einf));
    chk({nm, ".res"}, big_t'(res_s), big_t'(!einf));
    chk({nm, ".x3"}, big_t'(x3s), big_t'(ex));
    chk({nm, ".y3"}, big_t'(y3s), big_t'(ey));
    chk({nm, ".partial"}, big_t'(part), '0);
    if (!einf) chk({nm, ".latency_ok"}, big_t'(k <= 6 * 16 + 32), big_t'(1));
  endtask

  initial begin
    vec_t tv[5];
    int k;
    bit part, ok, ei;
    logic [15:0] hx, hy;
    big_t ex, ey, p521;
    int primes[7] = '{17, 23, 97, 251, 1009, 8191, 32749};
    tv[0] = '{p: 16'd23, a: 16'd1, x: 16'd3, y: 16'd10, ex: 16'd7, ey: 16'd12, inf: 1'b0};
    tv[1] = '{p: 16'd17, a: 16'd2, x: 16'd5, y: 16'd1, ex: 16'd6, ey: 16'd3, inf: 1'b0};
    tv[2] = '{p: 16'd23, a: 16'd1, x: 16'd5, y: 16'd0, ex: 16'd0, ey: 16'd0, inf: 1'b1};
    tv[3] = '{p: 16'd23, a: 16'd1, x: 16'd0, y: 16'd1, ex: 16'd6, ey: 16'd19, inf: 1'b0};
    tv[4] = '{p: 16'd23, a: 16'd1, x: 16'd3, y: 16'd12, ex: 16'd19, ey: 16'd0, inf: 1'b0};
    rs = 1'b1; rb = 1'b1;
    ps = '0; as = '0; xs = '0; ys = '0;
    pb = '0; ab = '0; xb = '0; yb = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.x3", big_t'(x3s), '0);
    chk("rst.y3", big_t'(y3s), '0);
    chk("rst.res", big_t'(res_s), '0);
    chk("rst.inf", big_t'(inf_s), '0);
    for (int i = 0; i < 5; i++) begin
      start_s(tv[i].p, tv[i].a, tv[i].x, tv[i].y);
      wait_s(k, part);
      check_s($sformatf("vec%0d", i), tv[i].ex, tv[i].ey, tv[i].inf, k, part);
    end
    start_s(16'd17, 16'd2, 16'd5, 16'd1);
    wait_s(k, part);
    check_s("hold_run", 16'd6, 16'd3, 1'b0, k, part);
    hx = x3s; hy = y3s; ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ps = 16'($urandom); xs = 16'($urandom); ys = 16'($urandom); as = 16'($urandom);
      @(posedge clk);
      #1;
      if (x3s !== hx || y3s !== hy || res_s !== 1'b1 || inf_s !== 1'b0) ok = 1'b0;
    end
    chk("hold.stable", big_t'(ok), big_t'(1));
    @(negedge clk);
    rs = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_after_done.x3", big_t'(x3s), '0);
    chk("rst_after_done.y3", big_t'(y3s), '0);
    chk("rst_after_done.res", big_t'(res_s), '0);
    start_s(16'd23, 16'd1, 16'd3, 16'd10);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rs = 1'b1;
    ps = 16'd17; as = 16'd2; xs = 16'd5; ys = 16'd1;
    @(posedge clk);
    #1;
    chk("midrst.x3", big_t'(x3s), '0);
    chk("midrst.y3", big_t'(y3s), '0);
    chk("midrst.res", big_t'(res_s), '0);
    chk("midrst.inf", big_t'(inf_s), '0);
    @(negedge clk);
    rs = 1'b0;
    @(posedge clk);
    #1;
    wait_s(k, part);
    check_s("midrst_run", 16'd6, 16'd3, 1'b0, k, part);
    for (int i = 0; i < 25; i++) begin
      logic [15:0] rp, ra, rx, ry;
      rp = 16'(primes[$urandom_range(0, 6)]);
      ra = 16'($urandom_range(0, int'(rp) - 1));
      rx = 16'($urandom_range(0, int'(rp) - 1));
      ry = 16'($urandom_range(0, int'(rp) - 1));
      ref_dbl(big_t'(rp), big_t'(ra), big_t'(rx), big_t'(ry), ex, ey, ei);
      start_s(rp, ra, rx, ry);
      wait_s(k, part);
      check_s($sformatf("rnd%0d", i), ex[15:0], ey[15:0], ei, k, part);
    end
`ifdef POINT_DOUBLING_REDUCE_IN_EN
    start_s(16'd23, 16'd24, 16'd26, 16'd33);
    wait_s(k, part);
    check_s("reduce", 16'd7, 16'd12, 1'b0, k, part);
`endif
    p521 = (big_t'(1) << 521) - big_t'(1);
    @(negedge clk);
    rb = 1'b1;
    pb = p521;
    ab = p521 - big_t'(3);
    xb = 530'h1d5c693f66c08ed03ad0f031f937443458f601fd098d3d0227b4bf62873af50740b0bb84aa157fc847bcf8dc16a8b2b8bfd8e2d0a7d39af04b089930ef6dad5c1b4;
    yb = 530'h144b7770963c63a39248865ff36b074151eac33549b224af5c8664c54012b818ed037b2b7c1a63ac89ebaa11e07db89fcee5b556e49764ee3fa66ea7ae61ac01823;
    ref_dbl(pb, ab, xb, yb, ex, ey, ei);
    @(negedge clk);
    rb = 1'b0;
    @(posedge clk);
    #1;
    k = 0;
    while (!res_b && !inf_b && k < 4000) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("p521.x3", x3b, ex);
    chk("p521.y3", y3b, ey);
    chk("p521.res", big_t'(res_b), big_t'(1));
    chk("p521.inf", big_t'(inf_b), big_t'(ei));
    chk("p521.latency_ok", big_t'(k <= 6 * W + 32), big_t'(1));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/point_doubling.md
Name: point_doubling

Overview:
- Computes the elliptic-curve point doubling 2P = (x3, y3) for P = (x1, y1) on y^2 = x^3 + a*x + b over GF(p).
- Uses affine coordinates.
- Multi-cycle, single-shot engine: operands are captured once after reset, and the block computes until done.
- Sits below the scalar-multiplication controller, beside point_addition.
- Contains its own sequential modular multiplier and modular inverter; no external arithmetic units.

Parameters:
- n, 530, operand width in bits. Covers P-192 through P-521. p must be odd prime with p < 2^(n-1).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- p  input  n  field prime.
- x1  input  n  input point x, reduced (< p).
- y1  input  n  input point y, reduced (< p).
- a  input  n  curve coefficient a, reduced (< p).
- x3  output  n  result x = 2P.x mod p.
- y3  output  n  result y = 2P.y mod p.
- result  output  1  high when x3/y3 are valid.
- infinity  output  1  high when 2P is the point at infinity.

Behaviour:
- Reset: any rising edge with reset=1 sets state LOAD and clears x3, y3, result and infinity to 0. Reset overrides everything, including mid-computation; the next run restarts from LOAD.
- LOAD: the first edge with reset=0 captures p, x1, y1, a into internal registers. Inputs are then ignored until the next reset.
- Branch after LOAD:
  - If y1 == 0, go to state INF: infinity=1, result=0, x3=y3=0.
  - Otherwise go to COMPUTE.
- COMPUTE sequence, all mod p:
  - t = x1^2
  - num = 3t + a
  - den = 2*y1
  - inv = den^-1
  - L = num*inv
  - x3' = L^2 - 2*x1
  - y3' = L*(x1 - x3') - y1
- Arithmetic units and rules:
  - Modular add/sub/double: one cycle each. Compute in n+1 bits, then apply one conditional ±p correction.
  - Multiplier: MSB-first interleaved shift-add, one bit per cycle, internal width n+2, two conditional subtractions per step. Takes n cycles plus setup.
  - Inverter: binary extended Euclid (u, v, x1', x2') with halving mod p (add p when odd, then shift). At most 2n iterations.
- DONE: x3 and y3 are loaded with x3' and y3', and result=1 on the same edge. The outputs stay frozen and result stays high until reset. Outputs are never partially updated: x3/y3 change only on the DONE edge.
- result and infinity are never both high.
- Latency from the LOAD edge to result=1 is at most 6n+32 cycles. The exact count is data dependent (inverter).
- x1 == 0 is valid: num = a.
- Results are always fully reduced (< p).

Optional Feature:
- Macro: POINT_DOUBLING_REDUCE_IN_EN.
- Defined: in LOAD, each of x1, y1 and a has p subtracted once if it is ≥ p. This adds one extra cycle (LOAD→REDUCE). Inputs < 2p are accepted, and the y1==0 test uses the reduced y1.
- Undefined: inputs must already be < p. There is no REDUCE state, and behaviour for unreduced inputs is undefined.

Test Plan:
- n=16, p=23, a=1, (x1,y1)=(3,10) -> result=1, infinity=0, (x3,y3)=(7,12), latency ≤ 6n+32.
- n=16, p=17, a=2, (x1,y1)=(5,1) -> (x3,y3)=(6,3); result stays 1 and outputs stable for ≥ 20 further cycles.
- n=16, p=23, a=1, (x1,y1)=(5,0) -> infinity=1, result=0, x3=y3=0.
- n=530, P-521 p=2^521-1, a=p-3, x1=0x1d5c693f66c08ed03ad0f031f937443458f601fd098d3d0227b4bf62873af50740b0bb84aa157fc847bcf8dc16a8b2b8bfd8e2d0a7d39af04b089930ef6dad5c1b4, y1=0x144b7770963c63a39248865ff36b074151eac33549b224af5c8664c54012b818ed037b2b7c1a63ac89ebaa11e07db89fcee5b556e49764ee3fa66ea7ae61ac01823 -> (x3,y3) equals the software model's 2P, result=1.
- Reset mid-run: start the p=23 case, assert reset for 1 cycle at cycle 10 with inputs changed to p=17, a=2, (5,1) -> outputs 0 during reset, final (6,3).
- Macro defined: p=23, a=24, (x1,y1)=(26,33) -> (7,12); macro undefined -> not tested.
